// File: rtl/reg_bank_wb_pkg.sv
// Shared register-file constants: register count, special register encodings
// ($zero, $sp, $ra) and the default stack-pointer reset value. The
// write-destination selector imports the same package so the 29/31 encodings
// are defined in one place.
package reg_bank_wb_pkg;

    localparam int          REG_COUNT        = 32;
    localparam int          IDX_W            = 5;
    localparam logic [4:0]  REG_ZERO         = 5'd0;
    localparam logic [4:0]  REG_SP           = 5'd29;
    localparam logic [4:0]  REG_RA           = 5'd31;
    localparam logic [31:0] SP_RESET_DEFAULT = 32'd227;

    // A write lands in the array only when enabled and not aimed at $zero.
    function automatic logic write_effective(input logic we, input logic [IDX_W-1:0] idx);
        return we && (idx != REG_ZERO);
    endfunction

endpackage

// File: rtl/reg_bank_wb_if.sv
// Bus between the datapath control (master) and the register bank (slave):
// write port, two read addresses, A/B load strobe and the four data returns.
interface reg_bank_wb_if
    import reg_bank_wb_pkg::*;
#(
    parameter int DATA_W = 32
);
    logic              reg_write;
    logic [IDX_W-1:0]  write_reg;
    logic [DATA_W-1:0] write_data;
    logic [IDX_W-1:0]  read_reg1;
    logic [IDX_W-1:0]  read_reg2;
    logic              load_ab;
    logic [DATA_W-1:0] read_data1;
    logic [DATA_W-1:0] read_data2;
    logic [DATA_W-1:0] a_out;
    logic [DATA_W-1:0] b_out;

    modport master (
        output reg_write, write_reg, write_data, read_reg1, read_reg2, load_ab,
        input  read_data1, read_data2, a_out, b_out
    );

    modport slave (
        input  reg_write, write_reg, write_data, read_reg1, read_reg2, load_ab,
        output read_data1, read_data2, a_out, b_out
    );
endinterface

// File: rtl/reg_bank_wb_reg_latch_en.sv
// DATA_W-wide enable register with asynchronous active-low clear; used for
// the A and B operand latches.
module reg_latch_en #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic [DATA_W-1:0] d_i,
    output logic [DATA_W-1:0] q_o
);
    logic [DATA_W-1:0] q_q;
    logic [DATA_W-1:0] q_d;

    // Next state: capture on enable, otherwise hold.
    always_comb begin
        q_d = q_q;
        if (en_i) begin
            q_d = d_i;
        end else begin
            q_d = q_q;
        end
    end

    // State register, cleared asynchronously.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

    assign q_o = q_q;
endmodule

// File: rtl/reg_bank_wb.sv
// 32 x DATA_W MIPS register file: one write port, two combinational read
// ports with optional same-cycle write forwarding, and registered A/B operand
// latches feeding the ALU source selectors.
module reg_bank_wb
    import reg_bank_wb_pkg::*;
#(
    parameter int                DATA_W   = 32,
    parameter logic [DATA_W-1:0] SP_RESET = DATA_W'(SP_RESET_DEFAULT),
    parameter bit                BYPASS   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    reg_bank_wb_if.slave bus
);
    logic [DATA_W-1:0] regs_q [REG_COUNT];
    logic [DATA_W-1:0] rd1_s;
    logic [DATA_W-1:0] rd2_s;
    logic [DATA_W-1:0] a_s;
    logic [DATA_W-1:0] b_s;
    logic              wr_eff_s;

    assign wr_eff_s = write_effective(bus.reg_write, bus.write_reg);

    // Register array: async clear ($sp to SP_RESET), write on edge except to $zero.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                regs_q[i] <= (i == int'(REG_SP)) ? SP_RESET : '0;
            end
        end else if (wr_eff_s) begin
            regs_q[bus.write_reg] <= bus.write_data;
        end
    end

    // Read port 1: $zero reads 0; a concurrent write to the same index is forwarded when BYPASS.
    always_comb begin
        rd1_s = '0;
        if (bus.read_reg1 == REG_ZERO) begin
            rd1_s = '0;
        end else if (BYPASS && wr_eff_s && (bus.write_reg == bus.read_reg1)) begin
            rd1_s = bus.write_data;
        end else begin
            rd1_s = regs_q[bus.read_reg1];
        end
    end

    // Read port 2: same rules as port 1.
    always_comb begin
        rd2_s = '0;
        if (bus.read_reg2 == REG_ZERO) begin
            rd2_s = '0;
        end else if (BYPASS && wr_eff_s && (bus.write_reg == bus.read_reg2)) begin
            rd2_s = bus.write_data;
        end else begin
            rd2_s = regs_q[bus.read_reg2];
        end
    end

    // A/B latches capture the post-forwarding read values so a same-edge
    // write is seen by the ALU when BYPASS is set.
    reg_latch_en #(.DATA_W(DATA_W)) u_a_latch (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (bus.load_ab),
        .d_i   (rd1_s),
        .q_o   (a_s)
    );

    reg_latch_en #(.DATA_W(DATA_W)) u_b_latch (
        .clk   (clk),
        .rst_n (reset),
        .en_i  (bus.load_ab),
        .d_i   (rd2_s),
        .q_o   (b_s)
    );

    assign bus.read_data1 = rd1_s;
    assign bus.read_data2 = rd2_s;
    assign bus.a_out      = a_s;
    assign bus.b_out      = b_s;
endmodule

// File: tb/tb_reg_bank_wb.sv
// Directed bench for reg_bank_wb. Two instances run the same stimulus: one
// with forwarding enabled, one with it disabled.
module tb_reg_bank_wb;
    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   checks = 0;
    int   errors = 0;

    reg_bank_wb_if #(.DATA_W(32)) bus_byp ();
    reg_bank_wb_if #(.DATA_W(32)) bus_nob ();

    reg_bank_wb #(.DATA_W(32), .SP_RESET(32'd227), .BYPASS(1'b1)) dut_byp (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_byp)
    );

    reg_bank_wb #(.DATA_W(32), .SP_RESET(32'd227), .BYPASS(1'b0)) dut_nob (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nob)
    );

    always #5 clk = ~clk;

    task automatic drive(input logic rw, input logic [4:0] wr, input logic [31:0] wd,
                         input logic [4:0] r1, input logic [4:0] r2, input logic ld);
        bus_byp.reg_write = rw; bus_byp.write_reg = wr; bus_byp.write_data = wd;
        bus_byp.read_reg1 = r1; bus_byp.read_reg2 = r2; bus_byp.load_ab = ld;
        bus_nob.reg_write = rw; bus_nob.write_reg = wr; bus_nob.write_data = wd;
        bus_nob.read_reg1 = r1; bus_nob.read_reg2 = r2; bus_nob.load_ab = ld;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd5, 1'b0);
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        check("rst_sp_byp",  bus_byp.read_data1, 32'd227);
        check("rst_sp_nob",  bus_nob.read_data1, 32'd227);
        check("rst_r5",      bus_byp.read_data2, 32'd0);
        check("rst_a",       bus_byp.a_out,      32'd0);
        check("rst_b",       bus_byp.b_out,      32'd0);

        // Write $t0 then read it back and latch into A.
        drive(1'b1, 5'd8, 32'hDEADBEEF, 5'd5, 5'd5, 1'b0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd5, 1'b1);
        #1;
        check("rd_r8_byp",   bus_byp.read_data1, 32'hDEADBEEF);
        check("rd_r8_nob",   bus_nob.read_data1, 32'hDEADBEEF);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd5, 1'b0);
        check("a_r8",        bus_byp.a_out,      32'hDEADBEEF);
        check("b_r5",        bus_byp.b_out,      32'd0);

        // Writes to $zero are discarded, even with forwarding enabled.
        drive(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0, 1'b0);
        #1;
        check("r0_same_cyc", bus_byp.read_data1, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b1);
        #1;
        check("r0_read",     bus_byp.read_data1, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd0, 5'd5, 1'b0);
        check("r0_a_byp",    bus_byp.a_out,      32'd0);
        check("r0_a_nob",    bus_nob.a_out,      32'd0);

        // Write $ra while reading it on both ports and loading A/B.
        drive(1'b1, 5'd31, 32'h00400008, 5'd31, 5'd31, 1'b1);
        #1;
        check("byp_rd2",     bus_byp.read_data2, 32'h00400008);
        check("byp_rd1",     bus_byp.read_data1, 32'h00400008);
        check("nob_rd2_old", bus_nob.read_data2, 32'd0);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd5, 5'd31, 1'b0);
        check("byp_b",       bus_byp.b_out,      32'h00400008);
        check("byp_a",       bus_byp.a_out,      32'h00400008);
        check("nob_b_old",   bus_nob.b_out,      32'd0);
        check("nob_rd2_new", bus_nob.read_data2, 32'h00400008);

        // Overwrite $sp, then pull reset between edges.
        drive(1'b1, 5'd29, 32'h12345678, 5'd29, 5'd31, 1'b1);
        tick();
        drive(1'b0, 5'd0, 32'h0, 5'd29, 5'd31, 1'b0);
        check("sp_new",      bus_byp.read_data1, 32'h12345678);
        check("sp_a_byp",    bus_byp.a_out,      32'h12345678);
        check("sp_a_nob",    bus_nob.a_out,      32'd227);
        check("sp_b",        bus_byp.b_out,      32'h00400008);
        #2;
        reset = 1'b0;
        #1;
        check("arst_sp",     bus_byp.read_data1, 32'd227);
        check("arst_ra",     bus_byp.read_data2, 32'd0);
        check("arst_a",      bus_byp.a_out,      32'd0);
        check("arst_b",      bus_byp.b_out,      32'd0);
        check("arst_b_nob",  bus_nob.b_out,      32'd0);

        // A write presented while reset is held is lost.
        drive(1'b1, 5'd8, 32'h11111111, 5'd5, 5'd5, 1'b1);
        tick();
        reset = 1'b1;
        drive(1'b0, 5'd0, 32'h0, 5'd8, 5'd5, 1'b0);
        #1;
        check("rst_wins_r8", bus_byp.read_data1, 32'd0);
        check("rst_wins_a",  bus_byp.a_out,      32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/reg_bank_wb.md
Name: reg_bank_wb

Overview:
- 32 x 32-bit MIPS general-purpose register file with two read ports, one write port and registered A/B operand latches.
- Sits directly downstream of the write-destination selector. Its write address comes from that selector: rt, 29 ($sp), 31 ($ra), rd or rs. Its write data comes from the write-back data selector.
- Read addresses come from instruction fields rs/rt. The latched outputs A/B feed the ALU source selectors on the following cycle.

Parameters:
- DATA_W, 32, register and data width.
- SP_RESET, 32'd227, reset value of register 29 ($sp).
- BYPASS, 1, when 1 a same-cycle write to a read address is forwarded to the combinational read port.

Ports:
- clk  input  1  single clock, all state updates on rising edge.
- reset  input  1  asynchronous, active-low; bank and latches cleared while low.
- reg_write  input  1  write enable for the register array.
- write_reg  input  5  destination index from the destination selector.
- write_data  input  DATA_W  value to write.
- read_reg1  input  5  rs index.
- read_reg2  input  5  rt index.
- load_ab  input  1  capture read data into A and B latches.
- read_data1  output  DATA_W  combinational rs value.
- read_data2  output  DATA_W  combinational rt value.
- a_out  output  DATA_W  registered rs value.
- b_out  output  DATA_W  registered rt value.

Behaviour:
- Reset (reset=0, asynchronous, independent of clk):
  - All registers go to 0, except register 29, which goes to SP_RESET.
  - a_out and b_out go to 0.
  - State holds while reset is low. Release takes effect at the next rising edge.
- Write: on a rising edge with reset=1 and reg_write=1, array[write_reg] <= write_data.
  - write_reg=0: the write is discarded; register 0 always reads 0.
  - reg_write=0: the array is unchanged.
- Combinational read: read_dataN = array[read_regN]. read_regN=0 always yields 0.
- Bypass (BYPASS=1):
  - Condition: reg_write=1, write_reg=read_regN and write_reg!=0.
  - read_dataN = write_data in that same cycle.
  - With BYPASS=0, read_dataN returns the old value until after the edge.
- A/B latches: on a rising edge with load_ab=1, a_out <= read_data1 and b_out <= read_data2, post-bypass. Otherwise they hold. Latency is 1 cycle from address to a_out/b_out.
- Simultaneous write and load_ab to the same index:
  - BYPASS=1: the latch captures the new value.
  - BYPASS=0: the latch captures the old value.
- No reserved or undefined indices: all 5-bit addresses are valid. Only register 0 is special.
- An undriven selector output upstream arrives as 0 and is therefore a discarded write by rule.
- Width: no arithmetic. Data is passed unmodified. No sign handling.
- Reset asserted mid-write: reset wins; the edge write is lost.

Decomposition:
- Shared package/include constants:
  - REG_ZERO=5'd0, REG_SP=5'd29, REG_RA=5'd31.
  - SP_RESET default.
  - Register count 32.
- These constants are shared with the destination selector so that the 29/31 encodings are defined once.
- One natural sub-module: reg_latch_en, a DATA_W-wide enable register with async active-low clear. It is instantiated twice, for A and B.
- The array and bypass logic live in the top module.

Test Plan:
- Reset: hold reset=0 for 2 cycles, then release. Expected:
  - read_reg1=29 gives read_data1=227.
  - read_reg2=5 gives read_data2=0.
  - a_out=0 and b_out=0.
- Write/read: write 32'hDEADBEEF to register 8 with reg_write=1, then read_reg1=8 → read_data1=32'hDEADBEEF on the next cycle. Pulse load_ab → a_out=32'hDEADBEEF one edge later.
- Register 0: write 32'hFFFFFFFF to write_reg=0, then read_reg1=0 → read_data1=0. a_out stays 0 after load_ab.
- Bypass with BYPASS=1: same cycle, reg_write=1, write_reg=31, write_data=32'h00400008, read_reg2=31, load_ab=1. Expected:
  - read_data2=32'h00400008 combinationally.
  - b_out=32'h00400008 after the edge.
- Bypass off with BYPASS=0: repeat the previous scenario with register 31 previously 0 → b_out=0 after the edge, and read_data2=32'h00400008 on the next cycle.
- Reset mid-operation: write 32'h12345678 to register 29, then assert reset asynchronously between edges. Expected:
  - read_data1 (read_reg1=29) returns 227 immediately, without a clock edge.
  - a_out and b_out return 0 immediately.
